// File: rtl/ddr_tx_sequencer.sv
// ddr_tx_sequencer: frame-level controller for the HDR-DDR transmit serializer.
// Steps the serializer through one write or read-command frame. The sequencer
// moves to the next mode on each i_tx_mode_done pulse, and it strobes the
// register file once per data byte.
//
// Ports:
//   i_sys_clk, i_sys_rst    clock and asynchronous active-low reset
//   i_engine_start          start request (sampled in IDLE only)
//   i_engine_rnw            1 = read command, 0 = write (latched at start)
//   i_engine_word_cnt       data words for a write (latched at start)
//   i_engine_restart        end pattern: 1 = restart, 0 = exit (latched at start)
//   i_engine_abort          abort request (latched while busy, before END)
//   i_tx_mode_done          serializer mode-complete pulse
//   o_tx_en, o_tx_mode      serializer enable and 4-bit mode select
//   o_tx_rnw                latched R/W bit for the serializer
//   o_regf_rd_en            one-cycle register-file byte advance
//   o_busy, o_done          frame in progress / one-cycle completion pulse
//   o_aborted               frame ended by abort (held until next start)
//   o_words_left            remaining data words
module ddr_tx_sequencer #(
    parameter int unsigned WC_W = 8
) (
    input  logic            i_sys_clk,
    input  logic            i_sys_rst,
    input  logic            i_engine_start,
    input  logic            i_engine_rnw,
    input  logic [WC_W-1:0] i_engine_word_cnt,
    input  logic            i_engine_restart,
    input  logic            i_engine_abort,
    input  logic            i_tx_mode_done,
    output logic            o_tx_en,
    output logic [3:0]      o_tx_mode,
    output logic            o_tx_rnw,
    output logic            o_regf_rd_en,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_aborted,
    output logic [WC_W-1:0] o_words_left
);

    localparam logic [3:0] M_ZEROS   = 4'd0;
    localparam logic [3:0] M_ADDR    = 4'd1;
    localparam logic [3:0] M_PRE     = 4'd2;
    localparam logic [3:0] M_ONE     = 4'd3;
    localparam logic [3:0] M_ZERO    = 4'd4;
    localparam logic [3:0] M_DATA    = 4'd5;
    localparam logic [3:0] M_PAR     = 4'd6;
    localparam logic [3:0] M_CRC     = 4'd7;
    localparam logic [3:0] M_TOK     = 4'd8;
    localparam logic [3:0] M_RESTART = 4'd9;
    localparam logic [3:0] M_EXIT    = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_PRE, S_CMD_RNW, S_CMD_ZEROS, S_CMD_ADDR, S_CMD_PAR,
        S_DATA_P1, S_DATA_P0, S_DATA_B1, S_DATA_B2, S_DATA_PAR,
        S_CRC_PRE, S_CRC_TOK, S_CRC_VAL, S_END
    } state_t;

    state_t state;
    logic   restart_q;
    logic   abort_q;
    logic   abort_now;
    logic   last_word;
    logic   no_words;

    // An abort arriving with the mode_done pulse takes effect on that pulse.
    assign abort_now = abort_q | i_engine_abort;
    assign last_word = (o_words_left == WC_W'(1));
    assign no_words  = (o_words_left == WC_W'(0));

    // Successor of a non-END state in an unaborted frame.
    function automatic state_t next_of(state_t s, logic rnw, logic zero_wc, logic last);
        case (s)
            S_CMD_PRE:   next_of = S_CMD_RNW;
            S_CMD_RNW:   next_of = S_CMD_ZEROS;
            S_CMD_ZEROS: next_of = S_CMD_ADDR;
            S_CMD_ADDR:  next_of = S_CMD_PAR;
            // The read data phase belongs to the receive path.
            S_CMD_PAR:   next_of = (rnw || zero_wc) ? S_END : S_DATA_P1;
            S_DATA_P1:   next_of = S_DATA_P0;
            S_DATA_P0:   next_of = S_DATA_B1;
            S_DATA_B1:   next_of = S_DATA_B2;
            S_DATA_B2:   next_of = S_DATA_PAR;
            S_DATA_PAR:  next_of = last ? S_CRC_PRE : S_DATA_P1;
            S_CRC_PRE:   next_of = S_CRC_TOK;
            S_CRC_TOK:   next_of = S_CRC_VAL;
            S_CRC_VAL:   next_of = S_END;
            default:     next_of = S_IDLE;
        endcase
    endfunction

    // Serializer mode driven while in a given state.
    function automatic logic [3:0] mode_of(state_t s, logic rnw, logic restart);
        case (s)
            S_CMD_PRE:   mode_of = M_PRE;
            S_CMD_RNW:   mode_of = rnw ? M_ONE : M_ZERO;
            S_CMD_ZEROS: mode_of = M_ZEROS;
            S_CMD_ADDR:  mode_of = M_ADDR;
            S_CMD_PAR:   mode_of = M_PAR;
            S_DATA_P1:   mode_of = M_ONE;
            S_DATA_P0:   mode_of = M_ZERO;
            S_DATA_B1:   mode_of = M_DATA;
            S_DATA_B2:   mode_of = M_DATA;
            S_DATA_PAR:  mode_of = M_PAR;
            S_CRC_PRE:   mode_of = M_PRE;
            S_CRC_TOK:   mode_of = M_TOK;
            S_CRC_VAL:   mode_of = M_CRC;
            S_END:       mode_of = restart ? M_RESTART : M_EXIT;
            default:     mode_of = M_ZEROS;
        endcase
    endfunction

    // Frame FSM with registered outputs.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state        <= S_IDLE;
            restart_q    <= 1'b0;
            abort_q      <= 1'b0;
            o_tx_en      <= 1'b0;
            o_tx_mode    <= 4'd0;
            o_tx_rnw     <= 1'b0;
            o_regf_rd_en <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_words_left <= WC_W'(0);
        end else begin
            o_regf_rd_en <= 1'b0;
            o_done       <= 1'b0;
            if (state == S_IDLE) begin
                if (i_engine_start) begin
                    state        <= S_CMD_PRE;
                    restart_q    <= i_engine_restart;
                    abort_q      <= 1'b0;
                    o_tx_en      <= 1'b1;
                    o_tx_mode    <= M_PRE;
                    o_tx_rnw     <= i_engine_rnw;
                    o_busy       <= 1'b1;
                    o_aborted    <= 1'b0;
                    o_words_left <= i_engine_word_cnt;
                end
            end else if (state == S_END) begin
                // Aborts are no longer accepted once END is reached.
                if (i_tx_mode_done) begin
                    state     <= S_IDLE;
                    o_tx_en   <= 1'b0;
                    o_tx_mode <= 4'd0;
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    o_aborted <= abort_q;
                end
            end else begin
                if (i_engine_abort) begin
                    abort_q <= 1'b1;
                end
                if (i_tx_mode_done) begin
                    if (abort_now) begin
                        state     <= S_END;
                        o_tx_mode <= M_EXIT;
                    end else begin
                        state     <= next_of(state, o_tx_rnw, no_words, last_word);
                        o_tx_mode <= mode_of(next_of(state, o_tx_rnw, no_words, last_word),
                                             o_tx_rnw, restart_q);
                        if (state == S_DATA_B1 || state == S_DATA_B2) begin
                            o_regf_rd_en <= 1'b1;
                        end
                        if (state == S_DATA_PAR) begin
                            o_words_left <= o_words_left - WC_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Self-checking bench for ddr_tx_sequencer. A frame model builds the expected
// mode list, the words-left value at each step and the read-strobe count from
// the frame parameters. The bench then drives mode_done pulses with random gaps.
module tb_ddr_tx_sequencer;

    localparam int unsigned WC_W = 8;

    logic            i_sys_clk = 1'b0;
    logic            i_sys_rst;
    logic            i_engine_start;
    logic            i_engine_rnw;
    logic [WC_W-1:0] i_engine_word_cnt;
    logic            i_engine_restart;
    logic            i_engine_abort;
    logic            i_tx_mode_done;
    logic            o_tx_en;
    logic [3:0]      o_tx_mode;
    logic            o_tx_rnw;
    logic            o_regf_rd_en;
    logic            o_busy;
    logic            o_done;
    logic            o_aborted;
    logic [WC_W-1:0] o_words_left;

    int checks = 0;
    int errors = 0;

    ddr_tx_sequencer #(.WC_W(WC_W)) dut (
        .i_sys_clk         (i_sys_clk),
        .i_sys_rst         (i_sys_rst),
        .i_engine_start    (i_engine_start),
        .i_engine_rnw      (i_engine_rnw),
        .i_engine_word_cnt (i_engine_word_cnt),
        .i_engine_restart  (i_engine_restart),
        .i_engine_abort    (i_engine_abort),
        .i_tx_mode_done    (i_tx_mode_done),
        .o_tx_en           (o_tx_en),
        .o_tx_mode         (o_tx_mode),
        .o_tx_rnw          (o_tx_rnw),
        .o_regf_rd_en      (o_regf_rd_en),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_aborted         (o_aborted),
        .o_words_left      (o_words_left)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    // Runs one frame. ab_req < 0 means no abort. Otherwise the abort is raised
    // at step (ab_req mod frame length), and it is ignored if that step is END.
    // poke = issue a stray start mid-frame. linger = spend one idle cycle after done.
    task automatic run_frame(input logic rnw, input int wc, input logic rs,
                             input int ab_req, input bit poke, input bit linger);
        int  modes[$];
        int  wls[$];
        int  n, ab, exp_rd, got_rd, gap;
        bit  pend_rd, ab_exp, skip_wl, exp_rd_now;
        bit  has_data;
        has_data = !rnw && (wc != 0);
        modes.push_back(2);            wls.push_back(wc);
        modes.push_back(rnw ? 3 : 4);  wls.push_back(wc);
        modes.push_back(0);            wls.push_back(wc);
        modes.push_back(1);            wls.push_back(wc);
        modes.push_back(6);            wls.push_back(wc);
        if (has_data) begin
            for (int w = 0; w < wc; w++) begin
                modes.push_back(3); wls.push_back(wc - w);
                modes.push_back(4); wls.push_back(wc - w);
                modes.push_back(5); wls.push_back(wc - w);
                modes.push_back(5); wls.push_back(wc - w);
                modes.push_back(6); wls.push_back(wc - w);
            end
            modes.push_back(2); wls.push_back(0);
            modes.push_back(8); wls.push_back(0);
            modes.push_back(7); wls.push_back(0);
        end
        modes.push_back(rs ? 9 : 10); wls.push_back(has_data ? 0 : wc);
        n = modes.size();
        ab = (ab_req >= 0) ? (ab_req % n) : -1;
        ab_exp = (ab >= 0) && (ab < n - 1);
        skip_wl = 1'b0;
        if (ab_exp) begin
            while (modes.size() > ab + 1) begin
                void'(modes.pop_back());
                void'(wls.pop_back());
            end
            modes.push_back(10);
            wls.push_back(wls[ab]);
            skip_wl = (modes[ab] == 6);
            n = modes.size();
        end
        exp_rd = 0;
        for (int k = 0; k < n - 1; k++) begin
            if (modes[k] == 5 && !(ab_exp && k == ab)) exp_rd++;
        end

        checks++;
        if (o_tx_en !== 1'b0) begin
            errors++; $display("FAIL gap_tx_en: got %b want 0", o_tx_en);
        end
        i_engine_start    = 1'b1;
        i_engine_rnw      = rnw;
        i_engine_word_cnt = WC_W'(wc);
        i_engine_restart  = rs;
        tick();
        i_engine_start    = 1'b0;
        i_engine_rnw      = 1'($urandom);
        i_engine_word_cnt = WC_W'($urandom);
        i_engine_restart  = 1'($urandom);

        got_rd  = 0;
        pend_rd = 1'b0;
        for (int i = 0; i < n; i++) begin
            gap = (i == ab) ? 2 + $urandom_range(0, 1) : $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (o_tx_en !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_ctl step %0d: en/busy/done got %b%b%b want 110",
                             i, o_tx_en, o_busy, o_done);
                end
                checks++;
                if (o_tx_mode !== 4'(modes[i])) begin
                    errors++;
                    $display("FAIL tx_mode step %0d: got %0d want %0d", i, o_tx_mode, modes[i]);
                end
                checks++;
                if (o_tx_rnw !== rnw) begin
                    errors++; $display("FAIL tx_rnw step %0d: got %b want %b", i, o_tx_rnw, rnw);
                end
                if (!(skip_wl && i == n - 1)) begin
                    checks++;
                    if (o_words_left !== WC_W'(wls[i])) begin
                        errors++;
                        $display("FAIL words_left step %0d: got %0d want %0d", i, o_words_left, wls[i]);
                    end
                end
                exp_rd_now = pend_rd && (g == 0);
                checks++;
                if (o_regf_rd_en !== exp_rd_now) begin
                    errors++;
                    $display("FAIL rd_en step %0d cyc %0d: got %b want %b", i, g, o_regf_rd_en, exp_rd_now);
                end
                if (o_regf_rd_en === 1'b1) got_rd++;
                i_tx_mode_done = (g == gap - 1);
                i_engine_abort = (i == ab) && (g == 0);
                i_engine_start = poke && (i == 2) && (g == 0);
                if (i_engine_start) begin
                    i_engine_rnw      = ~rnw;
                    i_engine_word_cnt = WC_W'(wc + 1);
                end
                tick();
                i_tx_mode_done = 1'b0;
                i_engine_abort = 1'b0;
                i_engine_start = 1'b0;
            end
            pend_rd = (modes[i] == 5) && !(ab_exp && i == ab);
        end

        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_tx_en !== 1'b0 || o_regf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done/busy/en/rd got %b%b%b%b want 1000",
                     o_done, o_busy, o_tx_en, o_regf_rd_en);
        end
        checks++;
        if (o_aborted !== ab_exp) begin
            errors++; $display("FAIL aborted: got %b want %b", o_aborted, ab_exp);
        end
        checks++;
        if (got_rd != exp_rd) begin
            errors++; $display("FAIL rd_count: got %0d want %0d", got_rd, exp_rd);
        end
        if (linger) begin
            i_tx_mode_done = 1'b1;
            tick();
            i_tx_mode_done = 1'b0;
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tx_en !== 1'b0 || o_aborted !== ab_exp) begin
                errors++;
                $display("FAIL idle_after: done/busy/en/aborted got %b%b%b%b want 000%b",
                         o_done, o_busy, o_tx_en, o_aborted, ab_exp);
            end
        end
    endtask

    task automatic test_reset();
        i_sys_rst = 1'b0;
        i_engine_start = 1'b0; i_engine_rnw = 1'b0; i_engine_word_cnt = '0;
        i_engine_restart = 1'b0; i_engine_abort = 1'b0; i_tx_mode_done = 1'b0;
        #3;
        checks++;
        if ({o_tx_en, o_tx_mode, o_tx_rnw, o_regf_rd_en, o_busy, o_done, o_aborted, o_words_left} !== '0) begin
            errors++;
            $display("FAIL reset_vals: en=%b mode=%0d rnw=%b rd=%b busy=%b done=%b ab=%b wl=%0d want all 0",
                     o_tx_en, o_tx_mode, o_tx_rnw, o_regf_rd_en, o_busy, o_done, o_aborted, o_words_left);
        end
        @(negedge i_sys_clk);
        i_sys_rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_write_single();
        run_frame(1'b0, 1, 1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_write_multi();
        run_frame(1'b0, 3, 1'b1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_read();
        run_frame(1'b1, 5, 1'b1, -1, 1'b0, 1'b1);
        run_frame(1'b1, 0, 1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        // Step 12 is the second DATA_B1 of the frame.
        run_frame(1'b0, 4, 1'b1, 12, 1'b0, 1'b1);
        run_frame(1'b0, 2, 1'b0, 1, 1'b0, 1'b1);
        run_frame(1'b1, 0, 1'b1, 4, 1'b0, 1'b1);
    endtask

    task automatic test_abort_in_end();
        // word_cnt=1 frame has 14 steps; step 13 is END, so the abort is ignored.
        run_frame(1'b0, 1, 1'b1, 13, 1'b0, 1'b1);
    endtask

    task automatic test_boundaries();
        run_frame(1'b0, 2, 1'b0, -1, 1'b1, 1'b1);
        run_frame(1'b0, 0, 1'b1, -1, 1'b0, 1'b1);
        run_frame(1'b0, 0, 1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 1, 1'b1, -1, 1'b0, 1'b0);
        run_frame(1'b1, 2, 1'b0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 2, 1'b0, 7, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            run_frame(1'($urandom), int'($urandom_range(0, 5)), 1'($urandom),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1,
                      1'($urandom), 1'($urandom));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        i_engine_start = 1'b1; i_engine_rnw = 1'b0;
        i_engine_word_cnt = WC_W'(1); i_engine_restart = 1'b0;
        tick();
        i_engine_start = 1'b0;
        for (int k = 0; k < 11; k++) begin
            i_tx_mode_done = 1'b1;
            tick();
        end
        i_tx_mode_done = 1'b0;
        checks++;
        if (o_tx_mode !== 4'd8 || o_busy !== 1'b1) begin
            errors++; $display("FAIL reach_crc_tok: mode=%0d busy=%b want 8 1", o_tx_mode, o_busy);
        end
        #2;
        i_sys_rst = 1'b0;
        #1;
        checks++;
        if ({o_tx_en, o_tx_mode, o_tx_rnw, o_regf_rd_en, o_busy, o_done, o_aborted, o_words_left} !== '0) begin
            errors++;
            $display("FAIL reset_mid: en=%b mode=%0d busy=%b done=%b wl=%0d want all 0",
                     o_tx_en, o_tx_mode, o_busy, o_done, o_words_left);
        end
        tick();
        @(negedge i_sys_clk);
        i_sys_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_tx_mode_done = 1'b1;
            tick();
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tx_en !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: done/busy/en got %b%b%b want 000", o_done, o_busy, o_tx_en);
            end
        end
        i_tx_mode_done = 1'b0;
        run_frame(1'b0, 1, 1'b0, -1, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_write_multi();
        test_read();
        test_abort();
        test_abort_in_end();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
